// File: rtl/ahb_multi_subordinate_interconnect_pkg.sv
// Shared constants and types for the AHB single-manager, multi-subordinate interconnect.
// Holds the default address map, HTRANS encodings and default-subordinate states.
package ahb_multi_subordinate_interconnect_pkg;

    localparam int NO_OF_SUBORDINATES = 4;
    localparam int AHB_ADDR_WIDTH     = 32;
    localparam int AHB_DATA_WIDTH     = 32;

    // Index 0 sits in the least-significant slice.
    localparam logic [NO_OF_SUBORDINATES*AHB_ADDR_WIDTH-1:0] DEF_SUB_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NO_OF_SUBORDINATES*AHB_ADDR_WIDTH-1:0] DEF_SUB_MASK =
        {4{32'hF000_0000}};

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } default_sub_state_e;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

endpackage

// File: rtl/ahb_multi_subordinate_interconnect_if.sv
// Bus bundle between the manager side, the subordinates and the interconnect.
// The interconnect uses the slave view; the environment driving it uses the master view.
interface ahb_multi_subordinate_interconnect_if
    import ahb_multi_subordinate_interconnect_pkg::*;
#(
    parameter int NUM_SUB    = NO_OF_SUBORDINATES,
    parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH = AHB_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0]         haddr;
    logic [1:0]                    htrans;
    logic                          hready;
    logic [DATA_WIDTH-1:0]         hrdata;
    logic                          hresp;
    logic                          hexokay;
    logic [NUM_SUB-1:0]            hselx;
    logic [NUM_SUB-1:0]            hreadyout_s;
    logic [NUM_SUB*DATA_WIDTH-1:0] hrdata_s;
    logic [NUM_SUB-1:0]            hresp_s;
    logic [NUM_SUB-1:0]            hexokay_s;

    modport slave (
        input  haddr, htrans, hreadyout_s, hrdata_s, hresp_s, hexokay_s,
        output hready, hrdata, hresp, hexokay, hselx
    );

    modport master (
        output haddr, htrans, hreadyout_s, hrdata_s, hresp_s, hexokay_s,
        input  hready, hrdata, hresp, hexokay, hselx
    );
endinterface

// File: rtl/ahb_multi_subordinate_interconnect_default_sub.sv
// Built-in default subordinate: two-cycle ERROR for accepted NONSEQ/SEQ transfers that
// hit no mapped subordinate, zero-wait OKAY otherwise.
module ahb_default_subordinate
    import ahb_multi_subordinate_interconnect_pkg::*;
(
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hready,
    input  logic       active,
    input  logic [1:0] htrans,
    input  logic       miss,
    output logic       hreadyout,
    output logic       hresp
);
    localparam logic [1:0] S_IDLE = D_IDLE;
    localparam logic [1:0] S_ERR1 = D_ERR1;
    localparam logic [1:0] S_ERR2 = D_ERR2;

    logic [1:0] state_q, state_d;
    logic       accept_err;

    assign accept_err = hready && htrans[1] && miss;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_err) state_d = S_ERR1;
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = accept_err ? S_ERR1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign hreadyout = !(active && (state_q == S_ERR1));
    assign hresp     = active && (state_q != S_IDLE);

endmodule

// File: rtl/ahb_multi_subordinate_interconnect.sv
// Single-manager AHB interconnect: priority address decode, registered data-phase
// select and zero-latency response mux with a built-in default subordinate.
module ahb_multi_subordinate_interconnect
    import ahb_multi_subordinate_interconnect_pkg::*;
#(
    parameter int NUM_SUB    = NO_OF_SUBORDINATES,
    parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH = AHB_DATA_WIDTH,
    parameter logic [NUM_SUB*ADDR_WIDTH-1:0] SUB_BASE = DEF_SUB_BASE,
    parameter logic [NUM_SUB*ADDR_WIDTH-1:0] SUB_MASK = DEF_SUB_MASK
)(
    input  logic hclk,
    input  logic hreset,
    ahb_multi_subordinate_interconnect_if.slave bus
);
    localparam int IDX_W = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;

    logic [NUM_SUB-1:0] hit;
    logic [NUM_SUB-1:0] sel;
    logic [IDX_W-1:0]   dec_idx;
    logic               miss;

    logic [IDX_W-1:0]   dsel_idx_q, dsel_idx_d;
    logic               dsel_def_q, dsel_def_d;

    logic               hready_w;
    logic               def_hreadyout;
    logic               def_hresp;

    generate
        for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_dec
            assign hit[gi] = ((bus.haddr & SUB_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]) ==
                              (SUB_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH] &
                               SUB_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]));
        end
    endgenerate

    // Scan from the top so the lowest-numbered hit is the one that sticks.
    always_comb begin
        dec_idx = '0;
        for (int i = NUM_SUB - 1; i >= 0; i--) begin
            if (hit[i]) dec_idx = IDX_W'(i);
        end
        miss = ~|hit;
        sel  = miss ? '0 : (NUM_SUB'(1) << dec_idx);
    end

    assign bus.hselx = sel;

    always_comb begin
        dsel_idx_d = dsel_idx_q;
        dsel_def_d = dsel_def_q;
        if (hready_w) begin
            dsel_idx_d = dec_idx;
            dsel_def_d = miss;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            dsel_idx_q <= '0;
            dsel_def_q <= 1'b1;
        end else begin
            dsel_idx_q <= dsel_idx_d;
            dsel_def_q <= dsel_def_d;
        end
    end

    ahb_default_subordinate u_default_sub (
        .hclk      (hclk),
        .hreset    (hreset),
        .hready    (hready_w),
        .active    (dsel_def_q),
        .htrans    (bus.htrans),
        .miss      (miss),
        .hreadyout (def_hreadyout),
        .hresp     (def_hresp)
    );

    always_comb begin
        if (dsel_def_q) begin
            hready_w    = def_hreadyout;
            bus.hresp   = def_hresp;
            bus.hexokay = 1'b0;
            bus.hrdata  = '0;
        end else begin
            hready_w    = bus.hreadyout_s[dsel_idx_q];
            bus.hresp   = bus.hresp_s[dsel_idx_q];
            bus.hexokay = bus.hexokay_s[dsel_idx_q];
            bus.hrdata  = bus.hrdata_s[dsel_idx_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.hready = hready_w;

endmodule
